// File: rtl/usb_pkg.sv
// +---------------------------------------------------------------------------+
// | usb_pkg : PID constants, token field offsets, scheduler state encoding     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package usb_pkg;

   localparam logic [7:0] c_PID_OUT   = 8'hE1;
   localparam logic [7:0] c_PID_IN    = 8'h69;
   localparam logic [7:0] c_PID_SETUP = 8'h2D;
   localparam logic [7:0] c_PID_DATA0 = 8'hC3;
   localparam logic [7:0] c_PID_DATA1 = 8'h4B;
   localparam logic [7:0] c_PID_ACK   = 8'hD2;
   localparam logic [7:0] c_PID_NAK   = 8'h5A;
   localparam logic [7:0] c_PID_STALL = 8'h1E;

   localparam int c_TOK_PID_LSB  = 0;
   localparam int c_TOK_ADDR_LSB = 8;
   localparam int c_TOK_EP_LSB   = 15;
   localparam int c_TOK_CRC_LSB  = 19;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RX_PID  = 3'd1,
      ST_RX_BODY = 3'd2,
      ST_TX_HS   = 3'd3,
      ST_TX_DATA = 3'd4,
      ST_WAIT_HS = 3'd5
   } state_t;

   // Upper nibble must be the ones-complement of the lower nibble.
   function automatic logic pid_valid(input logic [7:0] pid);
      return pid[7:4] == ~pid[3:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/usb_toggle_bank.sv
// +---------------------------------------------------------------------------+
// | usb_toggle_bank : per-endpoint DATA0/DATA1 toggles, clear wins over update |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module usb_toggle_bank #(
   parameter int NUM_EP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        i_sel,
   input  logic              i_setup,
   input  logic              i_flip_out,
   input  logic              i_flip_in,
   input  logic [NUM_EP-1:0] i_clr,
   output logic [NUM_EP-1:0] o_tog_out,
   output logic [NUM_EP-1:0] o_tog_in
);

   for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
      logic r_out;
      logic r_in;
      logic w_hit;

      assign w_hit = (i_sel == 4'(g));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_out <= 1'b0;
            r_in  <= 1'b0;
         end else if (i_clr[g]) begin
            r_out <= 1'b0;
            r_in  <= 1'b0;
         end else if (w_hit) begin
            if (i_setup) begin
               r_out <= 1'b1;
               r_in  <= 1'b1;
            end else begin
               if (i_flip_out) r_out <= ~r_out;
               if (i_flip_in)  r_in  <= ~r_in;
            end
         end
      end

      assign o_tog_out[g] = r_out;
      assign o_tog_in[g]  = r_in;
   end

endmodule

`default_nettype wire

// File: rtl/usb_txn_sched.sv
// +---------------------------------------------------------------------------+
// | usb_txn_sched : sequences SETUP/OUT/IN transactions and grants datapath    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module usb_txn_sched
   import usb_pkg::*;
#(
   parameter int NUM_EP      = 4,
   parameter int TIMEOUT_CYC = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        dev_addr,
   input  logic [23:0]       token_in,
   input  logic              token_in_strb,
   input  logic [7:0]        rx_pid,
   input  logic              rx_pid_strb,
   input  logic              rx_end,
   input  logic              rx_fail,
   input  logic [NUM_EP-1:0] ep_out_ready,
   input  logic [NUM_EP-1:0] ep_in_valid,
   input  logic [NUM_EP-1:0] ep_stall,
   input  logic [NUM_EP-1:0] ep_toggle_clr,
   output logic [3:0]        ep_sel,
   output logic              busy,
   output logic              ep_out_commit,
   output logic              ep_out_discard,
   output logic              ep_in_start,
   output logic              ep_in_done,
   output logic              ep_in_retry,
   output logic [7:0]        tx_pid,
   output logic              tx_pid_strb,
   output logic              tx_has_data,
   input  logic              tx_done
);

   localparam int c_TW = $clog2(TIMEOUT_CYC) + 1;

   state_t            r_state;
   logic [3:0]        r_ep;
   logic              r_is_setup;
   logic              r_data1;
   logic              r_rx_fail;
   logic [c_TW-1:0]   r_timer;

   logic [7:0]        w_tok_pid;
   logic [6:0]        w_tok_addr;
   logic [3:0]        w_tok_ep;
   logic [NUM_EP-1:0] w_tok_oh;
   logic [NUM_EP-1:0] w_cur_oh;
   logic [NUM_EP-1:0] w_tog_out;
   logic [NUM_EP-1:0] w_tog_in;
   logic              w_tok_ok;
   logic              w_tok_stall;
   logic              w_tok_valid;
   logic              w_tok_tog_in;
   logic              w_cur_stall;
   logic              w_cur_ready;
   logic              w_cur_tog_out;
   logic              w_timeout;
   logic              w_fail;
   logic              w_body_end;
   logic              w_set_setup;
   logic              w_flip_out;
   logic              w_flip_in;
   logic              w_unused_crc;

   assign w_tok_pid    = token_in[c_TOK_PID_LSB +: 8];
   assign w_tok_addr   = token_in[c_TOK_ADDR_LSB +: 7];
   assign w_tok_ep     = token_in[c_TOK_EP_LSB +: 4];
   assign w_unused_crc = ^token_in[c_TOK_CRC_LSB +: 5];

   assign w_tok_ok = token_in_strb && pid_valid(w_tok_pid)
                     && (w_tok_pid == c_PID_OUT || w_tok_pid == c_PID_IN || w_tok_pid == c_PID_SETUP)
                     && (w_tok_addr == dev_addr)
                     && ({1'b0, w_tok_ep} < 5'(NUM_EP));

   // One-hot masks avoid indexing per-endpoint vectors with a wider index.
   assign w_tok_oh      = NUM_EP'(1) << w_tok_ep;
   assign w_cur_oh      = NUM_EP'(1) << r_ep;
   assign w_tok_stall   = |(ep_stall & w_tok_oh);
   assign w_tok_valid   = |(ep_in_valid & w_tok_oh);
   assign w_tok_tog_in  = |(w_tog_in & w_tok_oh);
   assign w_cur_stall   = |(ep_stall & w_cur_oh);
   assign w_cur_ready   = |(ep_out_ready & w_cur_oh);
   assign w_cur_tog_out = |(w_tog_out & w_cur_oh);

   assign w_timeout   = (r_timer == c_TW'(TIMEOUT_CYC - 1));
   assign w_fail      = r_rx_fail | rx_fail;
   assign w_body_end  = (r_state == ST_RX_BODY) && rx_end && !w_fail;
   assign w_set_setup = w_body_end && r_is_setup;
   assign w_flip_out  = w_body_end && !r_is_setup && !w_cur_stall && w_cur_ready
                        && (r_data1 == w_cur_tog_out);
   assign w_flip_in   = (r_state == ST_WAIT_HS) && rx_pid_strb && (rx_pid == c_PID_ACK);

   usb_toggle_bank #(.NUM_EP(NUM_EP)) u_toggles (
      .clk        (clk),
      .rst        (rst),
      .i_sel      (r_ep),
      .i_setup    (w_set_setup),
      .i_flip_out (w_flip_out),
      .i_flip_in  (w_flip_in),
      .i_clr      (ep_toggle_clr),
      .o_tog_out  (w_tog_out),
      .o_tog_in   (w_tog_in)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_ep           <= '0;
         r_is_setup     <= 1'b0;
         r_data1        <= 1'b0;
         r_rx_fail      <= 1'b0;
         r_timer        <= '0;
         ep_sel         <= '0;
         busy           <= 1'b0;
         ep_out_commit  <= 1'b0;
         ep_out_discard <= 1'b0;
         ep_in_start    <= 1'b0;
         ep_in_done     <= 1'b0;
         ep_in_retry    <= 1'b0;
         tx_pid         <= '0;
         tx_pid_strb    <= 1'b0;
         tx_has_data    <= 1'b0;
      end else begin
         ep_out_commit  <= 1'b0;
         ep_out_discard <= 1'b0;
         ep_in_start    <= 1'b0;
         ep_in_done     <= 1'b0;
         ep_in_retry    <= 1'b0;
         tx_pid_strb    <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_tok_ok) begin
                  r_ep   <= w_tok_ep;
                  ep_sel <= w_tok_ep;
                  busy   <= 1'b1;
                  if (w_tok_pid == c_PID_IN) begin
                     tx_pid_strb <= 1'b1;
                     if (w_tok_stall) begin
                        tx_pid      <= c_PID_STALL;
                        tx_has_data <= 1'b0;
                        r_state     <= ST_TX_HS;
                     end else if (!w_tok_valid) begin
                        tx_pid      <= c_PID_NAK;
                        tx_has_data <= 1'b0;
                        r_state     <= ST_TX_HS;
                     end else begin
                        tx_pid      <= w_tok_tog_in ? c_PID_DATA1 : c_PID_DATA0;
                        tx_has_data <= 1'b1;
                        ep_in_start <= 1'b1;
                        r_state     <= ST_TX_DATA;
                     end
                  end else begin
                     r_is_setup <= (w_tok_pid == c_PID_SETUP);
                     r_timer    <= '0;
                     r_state    <= ST_RX_PID;
                  end
               end
            end

            ST_RX_PID: begin
               if (rx_pid_strb) begin
                  if (rx_pid == c_PID_DATA0 || rx_pid == c_PID_DATA1) begin
                     r_data1   <= (rx_pid == c_PID_DATA1);
                     r_rx_fail <= rx_fail;
                     r_state   <= ST_RX_BODY;
                  end else begin
                     r_state <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end else if (w_timeout) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end else begin
                  r_timer <= r_timer + c_TW'(1);
               end
            end

            ST_RX_BODY: begin
               if (rx_fail) r_rx_fail <= 1'b1;
               if (rx_end) begin
                  if (w_fail) begin
                     ep_out_discard <= 1'b1;
                     r_state        <= ST_IDLE;
                     busy           <= 1'b0;
                  end else begin
                     tx_pid_strb <= 1'b1;
                     tx_has_data <= 1'b0;
                     r_state     <= ST_TX_HS;
                     if (r_is_setup) begin
                        tx_pid        <= c_PID_ACK;
                        ep_out_commit <= 1'b1;
                     end else if (w_cur_stall) begin
                        tx_pid         <= c_PID_STALL;
                        ep_out_discard <= 1'b1;
                     end else if (!w_cur_ready) begin
                        tx_pid         <= c_PID_NAK;
                        ep_out_discard <= 1'b1;
                     end else if (r_data1 != w_cur_tog_out) begin
                        tx_pid         <= c_PID_ACK;
                        ep_out_discard <= 1'b1;
                     end else begin
                        tx_pid        <= c_PID_ACK;
                        ep_out_commit <= 1'b1;
                     end
                  end
               end
            end

            ST_TX_HS: begin
               if (tx_done) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end

            ST_TX_DATA: begin
               if (tx_done) begin
                  r_timer <= '0;
                  r_state <= ST_WAIT_HS;
               end
            end

            ST_WAIT_HS: begin
               if (rx_pid_strb) begin
                  if (rx_pid == c_PID_ACK) ep_in_done  <= 1'b1;
                  else                     ep_in_retry <= 1'b1;
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end else if (w_timeout) begin
                  ep_in_retry <= 1'b1;
                  r_state     <= ST_IDLE;
                  busy        <= 1'b0;
               end else begin
                  r_timer <= r_timer + c_TW'(1);
               end
            end

            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_usb_txn_sched.sv
// +---------------------------------------------------------------------------+
// | tb_usb_txn_sched : directed + random stimulus against a transaction model  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_usb_txn_sched;

   localparam int NUM_EP      = 4;
   localparam int TIMEOUT_CYC = 128;

   localparam int PH_IDLE = 0;
   localparam int PH_PID  = 1;
   localparam int PH_END  = 2;
   localparam int PH_HS   = 3;
   localparam int PH_DATA = 4;
   localparam int PH_WAIT = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [6:0]        dev_addr;
   logic [23:0]       token_in;
   logic              token_in_strb;
   logic [7:0]        rx_pid;
   logic              rx_pid_strb;
   logic              rx_end;
   logic              rx_fail;
   logic [NUM_EP-1:0] ep_out_ready;
   logic [NUM_EP-1:0] ep_in_valid;
   logic [NUM_EP-1:0] ep_stall;
   logic [NUM_EP-1:0] ep_toggle_clr;
   logic [3:0]        ep_sel;
   logic              busy;
   logic              ep_out_commit;
   logic              ep_out_discard;
   logic              ep_in_start;
   logic              ep_in_done;
   logic              ep_in_retry;
   logic [7:0]        tx_pid;
   logic              tx_pid_strb;
   logic              tx_has_data;
   logic              tx_done;

   usb_txn_sched #(.NUM_EP(NUM_EP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk            (clk),
      .rst            (rst),
      .dev_addr       (dev_addr),
      .token_in       (token_in),
      .token_in_strb  (token_in_strb),
      .rx_pid         (rx_pid),
      .rx_pid_strb    (rx_pid_strb),
      .rx_end         (rx_end),
      .rx_fail        (rx_fail),
      .ep_out_ready   (ep_out_ready),
      .ep_in_valid    (ep_in_valid),
      .ep_stall       (ep_stall),
      .ep_toggle_clr  (ep_toggle_clr),
      .ep_sel         (ep_sel),
      .busy           (busy),
      .ep_out_commit  (ep_out_commit),
      .ep_out_discard (ep_out_discard),
      .ep_in_start    (ep_in_start),
      .ep_in_done     (ep_in_done),
      .ep_in_retry    (ep_in_retry),
      .tx_pid         (tx_pid),
      .tx_pid_strb    (tx_pid_strb),
      .tx_has_data    (tx_has_data),
      .tx_done        (tx_done)
   );

   always #5 clk = ~clk;

   int     checks   = 0;
   int     failures = 0;
   longint cyc      = 0;

   // Transaction-level reference: toggles per endpoint, current phase, absolute deadline.
   bit          m_tog_o [NUM_EP];
   bit          m_tog_i [NUM_EP];
   int          m_ph;
   logic [1:0]  m_ep;
   bit          m_setup;
   bit          m_d1;
   bit          m_fail;
   longint      m_deadline;
   logic [7:0]  e_pid;
   logic [3:0]  e_sel;
   logic        e_strb, e_has, e_busy, e_commit, e_discard, e_start, e_done, e_retry;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_EP; i++) begin
         m_tog_o[i] = 1'b0;
         m_tog_i[i] = 1'b0;
      end
      m_ph = PH_IDLE; m_ep = '0; m_setup = 0; m_d1 = 0; m_fail = 0; m_deadline = 0;
      e_pid = '0; e_sel = '0; e_strb = 0; e_has = 0; e_busy = 0;
      e_commit = 0; e_discard = 0; e_start = 0; e_done = 0; e_retry = 0;
   endtask

   task automatic send(input logic [7:0] pid, input logic has, input int next_ph);
      e_pid = pid; e_strb = 1'b1; e_has = has; m_ph = next_ph;
   endtask

   task automatic model_edge();
      logic [7:0] p;
      logic [6:0] a;
      logic [3:0] en;
      cyc++;
      if (rst) begin
         model_reset();
         return;
      end
      e_strb = 0; e_commit = 0; e_discard = 0; e_start = 0; e_done = 0; e_retry = 0;
      case (m_ph)
         PH_IDLE: begin
            p  = token_in[7:0];
            a  = token_in[14:8];
            en = token_in[18:15];
            if (token_in_strb && a == dev_addr && en < 4'(NUM_EP)
                && (p == 8'hE1 || p == 8'h69 || p == 8'h2D)) begin
               m_ep  = en[1:0];
               e_sel = en;
               if (p == 8'h69) begin
                  if (ep_stall[m_ep])          send(8'h1E, 1'b0, PH_HS);
                  else if (!ep_in_valid[m_ep]) send(8'h5A, 1'b0, PH_HS);
                  else begin
                     send(m_tog_i[m_ep] ? 8'h4B : 8'hC3, 1'b1, PH_DATA);
                     e_start = 1'b1;
                  end
               end else begin
                  m_setup    = (p == 8'h2D);
                  m_ph       = PH_PID;
                  m_deadline = cyc + TIMEOUT_CYC;
               end
            end
         end
         PH_PID: begin
            if (rx_pid_strb) begin
               if (rx_pid == 8'hC3 || rx_pid == 8'h4B) begin
                  m_d1 = (rx_pid == 8'h4B); m_fail = rx_fail; m_ph = PH_END;
               end else m_ph = PH_IDLE;
            end else if (cyc == m_deadline) m_ph = PH_IDLE;
         end
         PH_END: begin
            if (rx_fail) m_fail = 1'b1;
            if (rx_end) begin
               if (m_fail) begin
                  e_discard = 1'b1; m_ph = PH_IDLE;
               end else if (m_setup) begin
                  send(8'hD2, 1'b0, PH_HS); e_commit = 1'b1;
                  m_tog_o[m_ep] = 1'b1; m_tog_i[m_ep] = 1'b1;
               end else if (ep_stall[m_ep]) begin
                  send(8'h1E, 1'b0, PH_HS); e_discard = 1'b1;
               end else if (!ep_out_ready[m_ep]) begin
                  send(8'h5A, 1'b0, PH_HS); e_discard = 1'b1;
               end else if (m_d1 != m_tog_o[m_ep]) begin
                  send(8'hD2, 1'b0, PH_HS); e_discard = 1'b1;
               end else begin
                  send(8'hD2, 1'b0, PH_HS); e_commit = 1'b1;
                  m_tog_o[m_ep] = ~m_tog_o[m_ep];
               end
            end
         end
         PH_HS:   if (tx_done) m_ph = PH_IDLE;
         PH_DATA: if (tx_done) begin m_ph = PH_WAIT; m_deadline = cyc + TIMEOUT_CYC; end
         PH_WAIT: begin
            if (rx_pid_strb) begin
               if (rx_pid == 8'hD2) begin
                  e_done = 1'b1; m_tog_i[m_ep] = ~m_tog_i[m_ep];
               end else e_retry = 1'b1;
               m_ph = PH_IDLE;
            end else if (cyc == m_deadline) begin
               e_retry = 1'b1; m_ph = PH_IDLE;
            end
         end
         default: m_ph = PH_IDLE;
      endcase
      for (int i = 0; i < NUM_EP; i++) begin
         if (ep_toggle_clr[i]) begin
            m_tog_o[i] = 1'b0;
            m_tog_i[i] = 1'b0;
         end
      end
      e_busy = (m_ph != PH_IDLE);
   endtask

   task automatic compare_outputs();
      check("busy",           32'(busy),           32'(e_busy));
      check("tx_pid_strb",    32'(tx_pid_strb),    32'(e_strb));
      check("ep_out_commit",  32'(ep_out_commit),  32'(e_commit));
      check("ep_out_discard", 32'(ep_out_discard), 32'(e_discard));
      check("ep_in_start",    32'(ep_in_start),    32'(e_start));
      check("ep_in_done",     32'(ep_in_done),     32'(e_done));
      check("ep_in_retry",    32'(ep_in_retry),    32'(e_retry));
      if (e_strb) begin
         check("tx_pid",      32'(tx_pid),      32'(e_pid));
         check("tx_has_data", 32'(tx_has_data), 32'(e_has));
      end
      if (e_busy) check("ep_sel", 32'(ep_sel), 32'(e_sel));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_outputs();
      token_in_strb = 0; rx_pid_strb = 0; rx_end = 0; rx_fail = 0; tx_done = 0;
      ep_toggle_clr = '0;
   endtask

   task automatic tok(input logic [23:0] t);
      token_in = t; token_in_strb = 1; step();
   endtask
   task automatic rxp(input logic [7:0] p);
      rx_pid = p; rx_pid_strb = 1; step();
   endtask
   task automatic rxe(input logic f);
      rx_end = 1; rx_fail = f; step();
   endtask
   task automatic txd();
      tx_done = 1; step();
   endtask

   function automatic logic [23:0] rand_token();
      logic [7:0] p;
      logic [6:0] a;
      logic [3:0] en;
      case ($urandom_range(0, 3))
         0:       p = 8'hE1;
         1:       p = 8'h69;
         2:       p = 8'h2D;
         default: p = 8'($urandom);
      endcase
      a  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : dev_addr;
      en = 4'($urandom_range(0, 5));
      return {5'($urandom), en, a, p};
   endfunction

   function automatic logic [7:0] rand_rx_pid();
      case ($urandom_range(0, 4))
         0:       return 8'hC3;
         1:       return 8'h4B;
         2:       return 8'hD2;
         3:       return 8'h5A;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1; dev_addr = '0; token_in = '0; token_in_strb = 0; rx_pid = '0; rx_pid_strb = 0;
      rx_end = 0; rx_fail = 0; ep_out_ready = '0; ep_in_valid = '0; ep_stall = '0;
      ep_toggle_clr = '0; tx_done = 0;
      model_reset();
      step(); step();
      rst = 0;
      check("reset_busy",   32'(busy),        32'h0);
      check("reset_tx_pid", 32'(tx_pid),      32'h0);
      check("reset_ep_sel", 32'(ep_sel),      32'h0);
      check("reset_strb",   32'(tx_pid_strb), 32'h0);

      // OUT ep1, DATA0 accepted, then the same DATA0 is a duplicate
      ep_out_ready = 4'b0010;
      tok(24'h0080E1);
      check("out_busy",   32'(busy),   32'h1);
      check("out_ep_sel", 32'(ep_sel), 32'h1);
      rxp(8'hC3); rxe(1'b0);
      check("out_ack_pid", 32'(tx_pid),        32'hD2);
      check("out_commit",  32'(ep_out_commit), 32'h1);
      txd();
      check("out_idle", 32'(busy), 32'h0);
      tok(24'h0080E1); rxp(8'hC3); rxe(1'b0);
      check("dup_ack_pid", 32'(tx_pid),         32'hD2);
      check("dup_discard", 32'(ep_out_discard), 32'h1);
      check("dup_commit",  32'(ep_out_commit),  32'h0);
      txd();

      // SETUP ep0 ignores ready and forces DATA1 for the following IN
      ep_out_ready = 4'b0000;
      tok(24'hF8002D); rxp(8'hC3); rxe(1'b0);
      check("setup_ack",    32'(tx_pid),        32'hD2);
      check("setup_commit", 32'(ep_out_commit), 32'h1);
      txd();
      ep_in_valid = 4'b0001;
      tok(24'h000069);
      check("in0_pid",   32'(tx_pid),      32'h4B);
      check("in0_has",   32'(tx_has_data), 32'h1);
      check("in0_start", 32'(ep_in_start), 32'h1);
      txd(); rxp(8'hD2);
      check("in0_done", 32'(ep_in_done), 32'h1);
      check("in0_idle", 32'(busy),       32'h0);

      // IN ep1: NAK then STALL
      ep_in_valid = 4'b0000;
      tok(24'h008069);
      check("in1_nak", 32'(tx_pid), 32'h5A);
      txd();
      ep_stall = 4'b0010;
      tok(24'h008069);
      check("in1_stall", 32'(tx_pid), 32'h1E);
      txd();
      ep_stall = 4'b0000;

      // IN ep1 with no host handshake: retry exactly TIMEOUT_CYC cycles after tx_done
      ep_in_valid = 4'b0010;
      tok(24'h008069);
      check("in1_d0", 32'(tx_pid), 32'hC3);
      txd();
      for (int k = 1; k <= TIMEOUT_CYC; k++) begin
         step();
         if (k < TIMEOUT_CYC) check("wait_no_retry", 32'(ep_in_retry), 32'h0);
      end
      check("timeout_retry", 32'(ep_in_retry), 32'h1);
      check("timeout_idle",  32'(busy),        32'h0);
      tok(24'h008069);
      check("retry_same_d0", 32'(tx_pid), 32'hC3);
      txd(); rxp(8'hD2);
      check("in1_done", 32'(ep_in_done), 32'h1);
      tok(24'h008069);
      check("in1_d1", 32'(tx_pid), 32'h4B);
      txd();
      ep_toggle_clr = 4'b0010;
      rxp(8'hD2);
      tok(24'h008069);
      check("clr_wins", 32'(tx_pid), 32'hC3);
      txd(); rxp(8'hD2);
      tok(24'h008069);
      check("in1_d1b", 32'(tx_pid), 32'h4B);
      txd();

      // Asynchronous reset while waiting for the host handshake
      rst = 1;
      #2;
      check("async_rst_busy", 32'(busy), 32'h0);
      step();
      rst = 0;
      tok(24'h008069);
      check("rst_clears_tog", 32'(tx_pid), 32'hC3);
      txd(); rxp(8'hD2);

      // OUT with a corrupted packet, then a token for another address
      ep_out_ready = 4'b0010;
      tok(24'h0080E1); rxp(8'hC3); rxe(1'b1);
      check("fail_discard", 32'(ep_out_discard), 32'h1);
      check("fail_no_hs",   32'(tx_pid_strb),    32'h0);
      tok(24'h0005E1);
      check("addr_busy", 32'(busy),        32'h0);
      check("addr_strb", 32'(tx_pid_strb), 32'h0);

      // Randomized traffic
      for (int seg = 0; seg < 40; seg++) begin
         automatic bit quiet = ($urandom_range(0, 3) == 0);
         dev_addr = 7'($urandom_range(0, 3));
         for (int c = 0; c < 250; c++) begin
            ep_out_ready = 4'($urandom);
            ep_in_valid  = 4'($urandom);
            ep_stall     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 5) == 0) begin
               token_in = rand_token(); token_in_strb = 1;
            end
            if ($urandom_range(0, quiet ? 400 : 5) == 0) begin
               rx_pid = rand_rx_pid(); rx_pid_strb = 1;
            end
            if ($urandom_range(0, quiet ? 400 : 5) == 0) rx_end = 1;
            if ($urandom_range(0, 19) == 0) rx_fail = 1;
            if ($urandom_range(0, 3) == 0) tx_done = 1;
            if ($urandom_range(0, 30) == 0) ep_toggle_clr = 4'($urandom);
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
